// File: rtl/alu_pipe.sv
// Two-stage elastic ALU pipeline: stage 1 registers the operation, stage 2 computes
// and registers result/flags. A WIDTH-bit accumulator can stand in for operand a.
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQ  = 3'b111
    } op_e;

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic             s1_acc_en_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;
    logic [WIDTH-1:0] acc_q;

    logic             s2_adv;
    logic             s2_load;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;
    logic             zero_d;
    logic             negative_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s2_load  = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

    // The accumulator is read at compute time, so it already holds the previous
    // op's result and back-to-back accumulation needs no forwarding path.
    always_comb begin
        op_a       = s1_acc_en_q ? acc_q : s1_a_q;
        add_full   = {1'b0, op_a} + {1'b0, s1_b_q};
        sub_full   = {1'b0, op_a} + {1'b0, ~s1_b_q} + (WIDTH + 1)'(1);
        add_ovf    = (op_a[MSB] == s1_b_q[MSB]) && (add_full[MSB] != op_a[MSB]);
        sub_ovf    = (op_a[MSB] != s1_b_q[MSB]) && (sub_full[MSB] != op_a[MSB]);
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (s1_op_q)
            OP_ADD: begin
                result_d   = add_full[MSB:0];
                carry_d    = add_full[WIDTH];
                overflow_d = add_ovf;
            end
            OP_SUB: begin
                result_d   = sub_full[MSB:0];
                carry_d    = sub_full[WIDTH];
                overflow_d = sub_ovf;
            end
            OP_NOT: result_d = ~op_a;
            OP_AND: result_d = op_a & s1_b_q;
            OP_OR:  result_d = op_a | s1_b_q;
            OP_XOR: result_d = op_a ^ s1_b_q;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, sub_full[MSB] ^ sub_ovf};
            OP_EQ:  result_d = {{(WIDTH-1){1'b0}}, op_a == s1_b_q};
            default: result_d = '0;
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[MSB];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_acc_en_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q     <= op_e'(op);
                    s1_acc_en_q <= acc_en;
                    s1_a_q      <= a;
                    s1_b_q      <= b;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
            end
            // A stage-2 load takes priority over a clear on the same edge.
            if (s2_load) begin
                acc_q <= result_d;
            end else if (acc_clr) begin
                acc_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=4): the driver pushes reference results on
// acceptance, a monitor pops and compares whenever the pipe presents a result.
module tb_alu_pipe;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         acc_en;
    logic         acc_clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    exp_t         sb_q[$];
    logic [W-1:0] acc_model = '0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference computed from signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux >= 8) ? ux - 16 : ux;
        int sy = (uy >= 8) ? uy - 16 : uy;
        int r  = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            3'd0: begin r = ux + uy; e.c = (r >= 16); e.v = (sx + sy > 7) || (sx + sy < -8); end
            3'd1: begin r = ux - uy; e.c = (ux >= uy); e.v = (sx - sy > 7) || (sx - sy < -8); end
            3'd2: r = 15 - ux;
            3'd3: r = ux & uy;
            3'd4: r = ux | uy;
            3'd5: r = ux ^ uy;
            3'd6: r = (sx < sy) ? 1 : 0;
            default: r = (ux == uy) ? 1 : 0;
        endcase
        e.res = W'(r & 15);
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        return e;
    endfunction

    // Called just after a falling edge: presents the inputs, then records acceptance.
    task automatic drive(input logic [2:0] o, input logic ae, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input bit use_ovr, input exp_t ovr,
                         output bit acc);
        exp_t e;
        in_valid = 1'b1;
        op = o; acc_en = ae; a = aa; b = bb;
        #1;
        acc = in_ready;
        if (acc) begin
            e = use_ovr ? ovr : model(o, ae ? acc_model : aa, bb);
            acc_model = e.res;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [2:0] o, input logic ae, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input bit use_ovr, input exp_t ovr);
        bit acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            drive(o, ae, aa, bb, use_ovr, ovr, acc);
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        bool_loop: for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            idle();
            out_ready = 1'b1;
            #3;
        end
        chk("drain_empty", sb_q.size(), 0);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v,
                                input logic z, input logic n);
        exp_t e;
        e.res = r; e.c = c; e.v = v; e.z = z; e.n = n;
        return e;
    endfunction

    // Monitor: compares the head of the scoreboard every cycle a result is shown,
    // so a held result is re-checked each stalled cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: result=%b with empty scoreboard at %0t", result, $time);
                end else begin
                    e = sb_q[0];
                    if ({result, carry, overflow, zero, negative} != e) begin
                        n_bad++;
                        $display("FAIL result: got res=%b c=%b v=%b z=%b n=%b expected res=%b c=%b v=%b z=%b n=%b at %0t",
                                 result, carry, overflow, zero, negative, e.res, e.c, e.v, e.z, e.n, $time);
                    end
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        int   n_acc;
        exp_t none = '0;
        rst = 1'b1; in_valid = 1'b0; op = '0; acc_en = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        #12;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        // add 0111+0001 with latency check
        @(negedge clk);
        drive(3'd0, 1'b0, 4'b0111, 4'b0001, 1'b1, mk(4'b1000, 1'b0, 1'b1, 1'b0, 1'b1), acc);
        chk("accept_immediate", int'(acc), 1);
        idle();
        #2;
        chk("latency_edge1_out_valid", int'(out_valid), 0);
        @(negedge clk);
        #2;
        chk("latency_edge2_out_valid", int'(out_valid), 1);
        drain();

        send(3'd0, 1'b0, 4'b1111, 4'b0001, 1'b1, mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));
        send(3'd1, 1'b0, 4'b0011, 4'b0101, 1'b1, mk(4'b1110, 1'b0, 1'b0, 1'b0, 1'b1));
        send(3'd6, 1'b0, 4'b1000, 4'b0001, 1'b1, mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
        send(3'd6, 1'b0, 4'b0111, 4'b1000, 1'b1, mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0));
        send(3'd7, 1'b0, 4'b0101, 4'b0101, 1'b1, mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // backpressure: four offers with out_ready low
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(3'($urandom_range(0, 7)), 1'b0, 4'($urandom), 4'($urandom), 1'b0, none, acc);
            if (acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready_low", int'(in_ready), 0);
        idle();
        out_ready = 1'b0;
        #2;
        chk("bp_out_valid_held", int'(out_valid), 1);
        drain();

        // accumulate chain
        idle();
        acc_clr = 1'b1;
        idle();
        acc_model = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(3'd0, 1'b1, 4'($urandom), 4'b0011, 1'b1,
                  (i == 0) ? mk(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0) :
                  (i == 1) ? mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0) :
                             mk(4'b1001, 1'b0, 1'b1, 1'b0, 1'b1), acc);
            chk("acc_back_to_back_accept", int'(acc), 1);
        end
        drain();

        // randomized stream
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                      1'b0, none, acc);
            else
                in_valid = 1'b0;
        end
        drain();

        // reset mid-stream with a held result
        send(3'd0, 1'b0, 4'b0011, 4'b0100, 1'b0, none);
        send(3'd5, 1'b0, 4'b1010, 4'b0110, 1'b0, none);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        #3;
        chk("pre_reset_out_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({carry, overflow, zero, negative}), 0);
        sb_q.delete();
        acc_model = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_mid_reset", int'(in_ready), 1);
        repeat (5) idle();
        send(3'd0, 1'b1, 4'b1111, 4'b0101, 1'b1, mk(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
